// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared types and constants for the SPI write-frame master.
//   state_t     - frame phase (IDLE, CMD, ADDR, DATA)
//   *_BITS      - field widths of the fixed command/address/data frame
//   CLK_DIV     - system clocks per SCLK period
//   last_bit()  - shift_count value at which the given phase ends
package spi_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    ADDR = 2'd2,
    DATA = 2'd3
  } state_t;

  localparam int unsigned CMD_BITS  = 8;
  localparam int unsigned ADDR_BITS = 24;
  localparam int unsigned DATA_BITS = 32;
  localparam int unsigned CLK_DIV   = 4;
  localparam int unsigned DIV_W     = $clog2(CLK_DIV);

  function automatic logic [4:0] last_bit(input state_t s);
    case (s)
      CMD:     return 5'(CMD_BITS - 1);
      ADDR:    return 5'(ADDR_BITS - 1);
      default: return 5'(DATA_BITS - 1);
    endcase
  endfunction

endpackage

// File: rtl/spi_master_if.sv
// spi_master_if: controller-side frame request plus the SPI pins.
//   enable/commands/Address/data_out : frame request from the local controller
//   CS/SCLK/MOSI                     : driven by the master
//   MISO                             : driven by the slave
// Modports: master (the SPI master), slave (controller + SPI slave side).
interface spi_master_if;
  logic        enable;
  logic [7:0]  commands;
  logic [23:0] Address;
  logic [31:0] data_out;
  logic        CS;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  modport master (
    input  enable, commands, Address, data_out, MISO,
    output CS, SCLK, MOSI
  );

  modport slave (
    output enable, commands, Address, data_out, MISO,
    input  CS, SCLK, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master sending 8-bit command, 24-bit address and
// 32-bit data MSB-first in one CS-low frame of 256 system clocks.
//   clk  - system clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - spi_master_if.master: frame request in, CS/SCLK/MOSI out, MISO in
// SCLK = clk/4; MOSI changes on SCLK fall, slave samples on SCLK rise.
// MISO is shifted into rx_reg during the DATA phase (internal only).
module spi_master
  import spi_master_pkg::*;
(
  input logic          clk,
  input logic          rst,
  spi_master_if.master bus
);

  state_t             state, state_next;
  logic [DIV_W-1:0]   clk_count;
  logic [31:0]        shift_reg;
  logic [4:0]         shift_count;
  logic               cs_q;
  logic [31:0]        rx_reg;

  logic               bit_end;
  logic               phase_end;

  // A bit slot ends on the last divider tick; a phase ends on its last bit.
  always_comb begin
    bit_end   = (state != IDLE) && (clk_count == DIV_W'(CLK_DIV - 1));
    phase_end = bit_end && (shift_count == last_bit(state));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (bus.enable) state_next = CMD;
      CMD:  if (phase_end)  state_next = ADDR;
      ADDR: if (phase_end)  state_next = DATA;
      DATA: if (phase_end)  state_next = IDLE;
      default:              state_next = IDLE;
    endcase
  end

  // Divider, shifter, chip select and receive register
  always_ff @(posedge clk) begin
    if (!rst) begin
      clk_count   <= '0;
      shift_reg   <= '0;
      shift_count <= '0;
      cs_q        <= 1'b1;
      rx_reg      <= '0;
    end else begin
      if (state == IDLE) begin
        clk_count <= '0;
        cs_q      <= 1'b1;
        if (bus.enable) begin
          cs_q        <= 1'b0;
          shift_reg   <= {bus.commands, 24'h0};
          shift_count <= '0;
        end
      end else begin
        clk_count <= clk_count + 1'b1;
        if (phase_end) begin
          // Next field is loaded directly so no idle bit appears between phases.
          shift_count <= '0;
          case (state)
            CMD:     shift_reg <= {bus.Address, 8'h0};
            ADDR:    shift_reg <= bus.data_out;
            default: begin
              shift_reg <= '0;
              cs_q      <= 1'b1;
            end
          endcase
        end else if (bit_end) begin
          shift_reg   <= shift_reg << 1;
          shift_count <= shift_count + 1'b1;
        end
        // Capture on the edge that raises SCLK, i.e. the slave's mid-bit point.
        if (state == DATA && clk_count == DIV_W'(1))
          rx_reg <= {rx_reg[30:0], bus.MISO};
      end
    end
  end

  // Output logic
  always_comb begin
    bus.CS   = cs_q;
    bus.SCLK = (state != IDLE) & clk_count[DIV_W-1];
    bus.MOSI = cs_q ? 1'b0 : shift_reg[31];
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: randomized self-checking bench for spi_master. The reference
// model describes a frame as a 64-bit word {cmd, addr, data} and derives the
// expected pin waveform per cycle from it (bit k on cycles 4k..4k+3, SCLK high
// in the second half of each bit).
module tb_spi_master;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  spi_master_if bus ();

  spi_master dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Runs one frame starting from the current negedge. Late changes to the
  // fields are applied at cycles 1 (cmd), 10 (addr) and 40 (data); the model
  // knows the fields are taken at cycle 0, 32 and 128 respectively.
  task automatic run_frame(
    input string       tag,
    input logic [7:0]  c,
    input logic [23:0] a,
    input logic [31:0] d,
    input bit          late,
    input logic [7:0]  c2,
    input logic [23:0] a2,
    input logic [31:0] d2,
    input logic [31:0] miso_pat,
    input bit          keep_enable,
    input int          abort_at
  );
    logic [63:0] frame;
    logic [63:0] captured;
    int          waits;
    int          pulses;
    logic        prev_sclk;

    frame = late ? {c, a2, d2} : {c, a, d};

    bus.commands = c;
    bus.Address  = a;
    bus.data_out = d;
    bus.enable   = 1'b1;
    bus.MISO     = 1'b0;

    waits = 0;
    for (int w = 0; w < 8; w++) begin
      @(negedge clk);
      waits++;
      if (bus.CS === 1'b0) break;
    end
    check({tag, " start_latency"}, 64'(waits), 64'd1);
    if (bus.CS !== 1'b0) return;

    captured  = '0;
    pulses    = 0;
    prev_sclk = 1'b0;
    for (int cyc = 0; cyc < 256; cyc++) begin
      if (cyc > 0) @(negedge clk);
      check({tag, " cs"},   64'(bus.CS),   64'd0);
      check({tag, " sclk"}, 64'(bus.SCLK), 64'((cyc % 4) >= 2));
      check({tag, " mosi"}, 64'(bus.MOSI), 64'(frame[63 - cyc / 4]));
      if (bus.SCLK === 1'b1 && prev_sclk === 1'b0) begin
        pulses++;
        captured = {captured[62:0], bus.MOSI};
      end
      prev_sclk = bus.SCLK;

      if (cyc == abort_at) begin
        rst = 1'b0;
        @(negedge clk);
        check({tag, " abort_cs"},   64'(bus.CS),   64'd1);
        check({tag, " abort_sclk"}, 64'(bus.SCLK), 64'd0);
        check({tag, " abort_mosi"}, 64'(bus.MOSI), 64'd0);
        rst = 1'b1;
        return;
      end
      if (cyc == 0 && !keep_enable) bus.enable = 1'b0;
      if (late && cyc == 1)  bus.commands = c2;
      if (late && cyc == 10) bus.Address  = a2;
      if (late && cyc == 40) bus.data_out = d2;
      if (cyc >= 128 && (cyc % 4) == 0) bus.MISO = miso_pat[31 - (cyc - 128) / 4];
    end

    @(negedge clk);
    check({tag, " end_cs"},   64'(bus.CS),   64'd1);
    check({tag, " end_sclk"}, 64'(bus.SCLK), 64'd0);
    check({tag, " end_mosi"}, 64'(bus.MOSI), 64'd0);
    check({tag, " pulses"},   64'(pulses),   64'd64);
    check({tag, " captured"}, captured,      frame);
    check({tag, " rx_reg"},   64'(dut.rx_reg), 64'(miso_pat));
  endtask

  initial begin
    logic [7:0]  rc;
    logic [23:0] ra;
    logic [31:0] rd;
    logic [31:0] rm;
    checks = 0;
    errors = 0;

    rst          = 1'b0;
    bus.enable   = 1'b1;
    bus.commands = 8'h69;
    bus.Address  = 24'h2AAAAC;
    bus.data_out = 32'h8B957B65;
    bus.MISO     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_cs",   64'(bus.CS),   64'd1);
      check("reset_sclk", 64'(bus.SCLK), 64'd0);
      check("reset_mosi", 64'(bus.MOSI), 64'd0);
    end
    bus.enable = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    check("idle_cs", 64'(bus.CS), 64'd1);

    run_frame("nominal", 8'h69, 24'h2AAAAC, 32'h8B957B65, 1'b0,
              8'h00, 24'h0, 32'h0, 32'hA5A5F00F, 1'b0, -1);
    @(negedge clk);

    run_frame("late", 8'h3C, 24'h123456, 32'hDEADBEEF, 1'b1,
              8'hC3, 24'hABCDEF, 32'h01234567, 32'h5A0FF0A5, 1'b0, -1);
    @(negedge clk);

    run_frame("b2b_first", 8'h02, 24'h00FF00, 32'hCAFEF00D, 1'b0,
              8'h00, 24'h0, 32'h0, 32'h0F0F0F0F, 1'b1, -1);
    run_frame("b2b_second", 8'h02, 24'h00FF00, 32'hCAFEF00D, 1'b0,
              8'h00, 24'h0, 32'h0, 32'hF0F0F0F0, 1'b0, -1);
    @(negedge clk);

    run_frame("abort", 8'h9F, 24'h777777, 32'h13579BDF, 1'b0,
              8'h00, 24'h0, 32'h0, 32'h0, 1'b1, 100);
    run_frame("after_abort", 8'h9F, 24'h777777, 32'h13579BDF, 1'b0,
              8'h00, 24'h0, 32'h0, 32'hFFFF0000, 1'b0, -1);

    for (int n = 0; n < 4; n++) begin
      rc = 8'($urandom);
      ra = 24'($urandom);
      rd = $urandom;
      rm = $urandom;
      run_frame("random", rc, ra, rd, 1'b0, 8'h00, 24'h0, 32'h0, rm,
                1'($urandom_range(0, 1)), -1);
    end
    bus.enable = 1'b0;
    repeat (300) @(negedge clk);
    check("final_idle_cs", 64'(bus.CS), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
